// File: rtl/la_capt_pkg.sv
// Shared constants for the logic-analyser capture controller:
// default widths and the capture FSM state encoding.
package la_capt_pkg;

    localparam int LA_ADDR_WIDTH = 12;
    localparam int LA_DATA_WIDTH = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/la_trig_match.sv
// Trigger qualifier: masked pattern compare on the probe stream.
// Optional edge qualification is enabled by macro LA_CAPT_EDGE_TRIG_EN:
// a trigger then also needs "no match" on the previous valid sample.
module la_trig_match
    import la_capt_pkg::*;
#(
    parameter int DATA_WIDTH = LA_DATA_WIDTH
) (
`ifdef LA_CAPT_EDGE_TRIG_EN
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  track,
    input  logic                  trig_edge,
`endif
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_vld,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    output logic                  hit
);

    logic match;

    assign match = sample_vld && ((sample_in & trig_mask) == (trig_value & trig_mask));

`ifdef LA_CAPT_EDGE_TRIG_EN
    logic prev_match_q;

    // Remember whether the last valid sample seen during a capture matched
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_match_q <= 1'b0;
        end else if (clr) begin
            prev_match_q <= 1'b0;
        end else if (track && sample_vld) begin
            prev_match_q <= match;
        end
    end

    assign hit = match && (!trig_edge || !prev_match_q);
`else
    assign hit = match;
`endif

endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyser capture controller: writes the probe stream into an
// external circular DPRAM, keeps pre_depth samples ahead of the trigger,
// fills the rest of the buffer after it, then serves readout by logical
// index (0 = oldest sample). Optional macro: LA_CAPT_EDGE_TRIG_EN adds the
// trig_edge input for edge-qualified triggering.
module la_capture_ctrl
    import la_capt_pkg::*;
#(
    parameter int ADDR_WIDTH = LA_ADDR_WIDTH,
    parameter int DATA_WIDTH = LA_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] pre_depth,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_vld,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_mask,
`ifdef LA_CAPT_EDGE_TRIG_EN
    input  logic                  trig_edge,
`endif
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_ren,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_pos
);

    localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] pre_q, pre_d;
    logic [ADDR_WIDTH-1:0] trig_pos_q, trig_pos_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic [ADDR_WIDTH:0]   post_target;
    logic                  trig_q, trig_d;
    logic                  rd_vld_q;
    logic                  capturing;
    logic                  arm_ok;
    logic                  wr_fire;
    logic                  hit;

    assign capturing   = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
    assign arm_ok      = arm && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // abort wins over a sample arriving in the same cycle
    assign wr_fire     = capturing && sample_vld && !abort;
    assign cnt_inc     = cnt_q + 1'b1;
    // Post-trigger writes (trigger sample included) that complete the buffer
    assign post_target = (ADDR_WIDTH+1)'(MEM_DEPTH) - {1'b0, pre_q};

    la_trig_match #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_trig (
`ifdef LA_CAPT_EDGE_TRIG_EN
        .clk        (clk),
        .rst        (rst),
        .clr        (abort || arm_ok),
        .track      (capturing),
        .trig_edge  (trig_edge),
`endif
        .sample_in  (sample_in),
        .sample_vld (sample_vld),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .hit        (hit)
    );

    // Capture FSM next-state, write pointer, counters and trigger latch
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        pre_d      = pre_q;
        trig_pos_d = trig_pos_q;
        cnt_d      = cnt_q;
        trig_d     = trig_q;
        if (abort) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        wr_ptr_d = '0;
                        cnt_d    = '0;
                        pre_d    = pre_depth;
                        trig_d   = 1'b0;
                        state_d  = (pre_depth == '0) ? ST_WAIT : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (wr_fire) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (cnt_inc == {1'b0, pre_q}) begin
                            cnt_d   = '0;
                            state_d = ST_WAIT;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wr_fire) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (hit) begin
                            trig_pos_d = wr_ptr_q;
                            trig_d     = 1'b1;
                            cnt_d      = (ADDR_WIDTH+1)'(1);
                            // With pre_depth = MEM_DEPTH-1 the trigger sample fills the buffer
                            state_d    = (post_target == (ADDR_WIDTH+1)'(1)) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (wr_fire) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        cnt_d    = cnt_inc;
                        if (cnt_inc == post_target) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            pre_q      <= '0;
            trig_pos_q <= '0;
            cnt_q      <= '0;
            trig_q     <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            pre_q      <= pre_d;
            trig_pos_q <= trig_pos_d;
            cnt_q      <= cnt_d;
            trig_q     <= trig_d;
            // Only flag read data if we are still in DONE when it returns
            rd_vld_q   <= ram_ren && (state_d == ST_DONE);
        end
    end

    assign ram_wen   = wr_fire;
    assign ram_waddr = wr_fire ? wr_ptr_q : '0;
    assign ram_din   = wr_fire ? sample_in : '0;

    // Logical index 0 is the oldest retained sample, pre_depth before trigger
    assign ram_ren   = (state_q == ST_DONE) && rd_en;
    assign ram_raddr = ram_ren ? (trig_pos_q - pre_q + rd_idx) : '0;
    assign rd_vld    = rd_vld_q;
    assign rd_data   = rd_vld_q ? ram_dout : '0;

    assign busy      = capturing;
    assign done      = (state_q == ST_DONE);
    assign triggered = trig_q;
    assign trig_pos  = trig_pos_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Testbench for la_capture_ctrl (ADDR_WIDTH=4, DATA_WIDTH=8) with a
// behavioural DPRAM, a capture model and a readout scoreboard.
module tb_la_capture_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst, arm, abort, sample_vld, rd_en;
    logic [AW-1:0] pre_depth, rd_idx, ram_waddr, ram_raddr, trig_pos;
    logic [DW-1:0] sample_in, trig_value, trig_mask, rd_data, ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic          rd_vld, ram_wen, ram_ren, busy, triggered, done;
`ifdef LA_CAPT_EDGE_TRIG_EN
    logic          trig_edge = 1'b0;
`endif

    always #5 clk = ~clk;

    la_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .abort      (abort),
        .pre_depth  (pre_depth),
        .sample_in  (sample_in),
        .sample_vld (sample_vld),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
`ifdef LA_CAPT_EDGE_TRIG_EN
        .trig_edge  (trig_edge),
`endif
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data),
        .ram_waddr  (ram_waddr),
        .ram_din    (ram_din),
        .ram_wen    (ram_wen),
        .ram_raddr  (ram_raddr),
        .ram_ren    (ram_ren),
        .ram_dout   (ram_dout),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .trig_pos   (trig_pos)
    );

    // Behavioural DPRAM, one-cycle registered read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_din;
        if (ram_ren) ram_dout <= mem[ram_raddr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Readout scoreboard
    logic [DW-1:0] exp_q[$];
    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 32'(rd_vld), 32'd0);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Capture model: the ordered list of every written sample
    logic [DW-1:0] rec[$];
    int            t_idx;
    int            m_pre;
    logic [DW-1:0] m_val, m_mask;

    function automatic bit is_match(input logic [DW-1:0] s);
        return (s & m_mask) == (m_val & m_mask);
    endfunction

    function automatic logic [DW-1:0] gen_sample(input int mode, input int n);
        case (mode)
            0:       return DW'(n);
            1:       return DW'($urandom);
            default: return (n == 20) ? 8'h00 : 8'h55;
        endcase
    endfunction

    // Arm, then stream samples until the model says the buffer is full
    // or max_writes samples have been written
    task automatic run_capture(input int pre, input logic [DW-1:0] val, input logic [DW-1:0] mask,
                               input bit edg, input int mode, input int max_writes, output bit ok);
        int       cyc;
        int       idx;
        bit       vld;
        bit       fin;
        logic [DW-1:0] s;
        m_pre = pre; m_val = val; m_mask = mask;
        rec.delete();
        t_idx = -1;
        fin   = 0;
        cyc   = 0;
        pre_depth  = AW'(pre);
        trig_value = val;
        trig_mask  = mask;
`ifdef LA_CAPT_EDGE_TRIG_EN
        trig_edge  = edg;
`endif
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        while (!fin && cyc < 1500 && rec.size() < max_writes) begin
            vld = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
            s   = gen_sample(mode, rec.size());
            sample_in  = s;
            sample_vld = vld;
            #1;
            if (vld) begin
                idx = rec.size();
                chk("wen", 32'(ram_wen), 32'd1);
                chk("waddr", 32'(ram_waddr), 32'(idx % DEPTH));
                chk("wdata", 32'(ram_din), 32'(s));
                rec.push_back(s);
                if (t_idx < 0 && idx >= pre && is_match(s) &&
                    (!edg || idx == 0 || !is_match(rec[idx-1])))
                    t_idx = idx;
                if (t_idx >= 0 && rec.size() == t_idx + DEPTH - pre)
                    fin = 1;
            end else begin
                chk("wen_idle", 32'(ram_wen), 32'd0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        sample_vld = 1'b0;
        ok = fin;
    endtask

    // Status after a complete capture; also no writes in DONE
    task automatic check_done(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_trig"}, 32'(triggered), 32'd1);
        chk({tag, "_pos"}, 32'(trig_pos), 32'(t_idx % DEPTH));
        sample_vld = 1'b1;
        #1;
        chk({tag, "_wen_done"}, 32'(ram_wen), 32'd0);
        sample_vld = 1'b0;
    endtask

    task automatic rd(input int idx);
        rd_en  = 1'b1;
        rd_idx = AW'(idx);
        exp_q.push_back(rec[t_idx - m_pre + idx]);
        @(posedge clk); #1;
        chk("rd_latency", 32'(rd_vld), 32'd1);
    endtask

    task automatic rd_end();
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_stopped(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_trig"}, 32'(triggered), 32'd0);
        chk({tag, "_wen"}, 32'(ram_wen), 32'd0);
    endtask

    bit ok;

    initial begin
        rst = 1'b1; arm = 1'b1; abort = 1'b0; sample_vld = 1'b1; sample_in = 8'h3C;
        rd_en = 1'b0; rd_idx = '0; pre_depth = '0; trig_value = '0; trig_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        // reset state, with arm and sample_vld held high underneath rst
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_trig", 32'(triggered), 32'd0);
        chk("rst_pos", 32'(trig_pos), 32'd0);
        chk("rst_wen", 32'(ram_wen), 32'd0);
        chk("rst_ren", 32'(ram_ren), 32'd0);
        chk("rst_rdvld", 32'(rd_vld), 32'd0);
        rst = 1'b0; arm = 1'b0; sample_vld = 1'b0;
        // readout request outside DONE is ignored
        rd_en = 1'b1;
        #1;
        chk("idle_ren", 32'(ram_ren), 32'd0);
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(posedge clk); #1;

        // basic capture
        run_capture(4, 8'h0A, 8'hFF, 0, 0, 1000, ok);
        chk("basic_complete", 32'(ok), 32'd1);
        if (ok) begin
            check_done("basic");
            chk("basic_pos_abs", 32'(trig_pos), 32'd10);
            rd(0); rd(4); rd(15); rd_end();
        end

        // zero pre-trigger
        run_capture(0, 8'h00, 8'hFF, 0, 0, 1000, ok);
        chk("zero_complete", 32'(ok), 32'd1);
        if (ok) begin
            check_done("zero");
            chk("zero_writes", 32'(rec.size()), 32'd16);
            rd(0); rd_end();
        end

        // wrap-around
        run_capture(8, 8'h1C, 8'hFF, 0, 0, 1000, ok);
        chk("wrap_complete", 32'(ok), 32'd1);
        if (ok) begin
            check_done("wrap");
            rd(0); rd(8); rd(15); rd_end();
        end

        // match during PRE ignored
        run_capture(4, 8'h02, 8'h0F, 0, 0, 1000, ok);
        chk("pre_complete", 32'(ok), 32'd1);
        if (ok) begin
            check_done("preign");
            chk("preign_pos_abs", 32'(trig_pos), 32'd2);
        end

        // abort in POST
        run_capture(4, 8'h0A, 8'hFF, 0, 0, 13, ok);
        chk("abort_busy_before", 32'(busy), 32'd1);
        abort = 1'b1; sample_vld = 1'b1; sample_in = 8'h77;
        #1;
        chk("abort_wen_same", 32'(ram_wen), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        #1;
        check_stopped("abort");
        sample_vld = 1'b0;

        // reset in POST
        run_capture(4, 8'h0A, 8'hFF, 0, 0, 13, ok);
        rst = 1'b1; sample_vld = 1'b1;
        @(posedge clk); #1;
        check_stopped("rstcap");
        chk("rstcap_pos", 32'(trig_pos), 32'd0);
        rst = 1'b0; sample_vld = 1'b0;
        @(posedge clk); #1;

        // fresh capture after abort/reset starts again from address 0
        run_capture(4, 8'h0A, 8'hFF, 0, 0, 1000, ok);
        chk("rearm_complete", 32'(ok), 32'd1);
        if (ok) begin
            check_done("rearm");
            rd(0); rd(15); rd_end();
        end

        // randomised captures
        for (int r = 0; r < 8; r++) begin
            logic [DW-1:0] mk;
            mk = DW'(3) << $urandom_range(6);
            run_capture(int'($urandom_range(15)), DW'($urandom), mk, 0, 1, 1000, ok);
            chk("rand_complete", 32'(ok), 32'd1);
            if (ok) begin
                check_done("rand");
                for (int k = 0; k < 4; k++) rd(int'($urandom_range(15)));
                rd_end();
            end
        end

`ifdef LA_CAPT_EDGE_TRIG_EN
        // edge trigger: held 0x55 must not trigger, 0x00 then 0x55 must
        run_capture(4, 8'h55, 8'hFF, 1, 2, 1000, ok);
        chk("edge_complete", 32'(ok), 32'd1);
        if (ok) begin
            check_done("edge");
            chk("edge_index", 32'(t_idx), 32'd21);
            rd(0); rd(1); rd_end();
        end
        trig_edge = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
